// File: rtl/mem_access_unit.sv
// Load/store unit between a core request port and an Avalon-MM style master port.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  loadcontrol,
  input  logic [1:0]  store_size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rt_old,
  input  logic [15:0] imm,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        err,
  output logic        stall,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam logic [2:0] LcLb  = 3'b000;
  localparam logic [2:0] LcLbu = 3'b001;
  localparam logic [2:0] LcLh  = 3'b010;
  localparam logic [2:0] LcLhu = 3'b011;
  localparam logic [2:0] LcLui = 3'b100;
  localparam logic [2:0] LcLw  = 3'b101;
  localparam logic [2:0] LcLwl = 3'b110;
  localparam logic [2:0] LcLwr = 3'b111;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] avm_address_q, avm_address_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_write_q, avm_write_d;
  logic [3:0]  avm_byteenable_q, avm_byteenable_d;
  logic [31:0] avm_writedata_q, avm_writedata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        err_q, err_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rt_old_q, rt_old_d;
  logic        is_write_q, is_write_d;

  logic        accept;
  logic        is_lui;
  logic        misalign;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [31:0] load_data;

  assign accept = req_valid && (state_q == StIdle);
  assign is_lui = !req_write && (loadcontrol == LcLui);

`ifdef MEM_ALIGN_CHECK_EN
  // LWL/LWR and byte accesses are legal at any offset.
  always_comb begin
    misalign = 1'b0;
    if (req_write) begin
      if (store_size == SzHalf)      misalign = addr[0];
      else if (store_size != SzByte) misalign = |addr[1:0];
    end else begin
      unique case (loadcontrol)
        LcLh, LcLhu: misalign = addr[0];
        LcLw:        misalign = |addr[1:0];
        default:     misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  // Store lane selection; halfword placement ignores addr[0], forcing alignment.
  always_comb begin
    req_be = 4'b1111;
    req_wd = wdata;
    if (req_write) begin
      unique case (store_size)
        SzByte: begin
          req_be = 4'b0001 << addr[1:0];
          req_wd = {4{wdata[7:0]}};
        end
        SzHalf: begin
          req_be = 4'b0011 << {addr[1], 1'b0};
          req_wd = {2{wdata[15:0]}};
        end
        default: begin
          req_be = 4'b1111;
          req_wd = wdata;
        end
      endcase
    end
  end

  // Load extraction and LWL/LWR merge on the word captured this cycle.
  always_comb begin
    logic [31:0] shifted;
    logic [15:0] half;
    logic [4:0]  shl;
    logic [4:0]  shr;
    shr       = {off_q, 3'b000};
    shl       = {~off_q, 3'b000};
    shifted   = avm_readdata >> shr;
    half      = off_q[1] ? avm_readdata[31:16] : avm_readdata[15:0];
    load_data = 32'h0;
    unique case (op_q)
      LcLb:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      LcLbu:   load_data = {24'h0, shifted[7:0]};
      LcLh:    load_data = {{16{half[15]}}, half};
      LcLhu:   load_data = {16'h0, half};
      LcLw:    load_data = avm_readdata;
      LcLwl:   load_data = (avm_readdata << shl) | (rt_old_q & ~(32'hFFFF_FFFF << shl));
      LcLwr:   load_data = (avm_readdata >> shr) | (rt_old_q & ~(32'hFFFF_FFFF >> shr));
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    avm_address_d    = avm_address_q;
    avm_read_d       = avm_read_q;
    avm_write_d      = avm_write_q;
    avm_byteenable_d = avm_byteenable_q;
    avm_writedata_d  = avm_writedata_q;
    resp_valid_d     = 1'b0;
    resp_data_d      = resp_data_q;
    err_d            = err_q;
    op_d             = op_q;
    off_d            = off_q;
    rt_old_d         = rt_old_q;
    is_write_d       = is_write_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_lui || misalign) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_data_d  = misalign ? 32'h0 : {imm, 16'h0000};
            err_d        = misalign;
          end else begin
            state_d          = StBus;
            avm_address_d    = {addr[31:2], 2'b00};
            avm_read_d       = !req_write;
            avm_write_d      = req_write;
            avm_byteenable_d = req_be;
            avm_writedata_d  = req_wd;
            op_d             = loadcontrol;
            off_d            = addr[1:0];
            rt_old_d         = rt_old;
            is_write_d       = req_write;
            err_d            = 1'b0;
          end
        end
      end
      StBus: begin
        if (!avm_waitrequest) begin
          state_d      = StResp;
          avm_read_d   = 1'b0;
          avm_write_d  = 1'b0;
          resp_valid_d = 1'b1;
          resp_data_d  = is_write_q ? 32'h0 : load_data;
        end
      end
      StResp: begin
        state_d     = StIdle;
        resp_data_d = 32'h0;
        err_d       = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      avm_address_q    <= 32'h0;
      avm_read_q       <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_byteenable_q <= 4'h0;
      avm_writedata_q  <= 32'h0;
      resp_valid_q     <= 1'b0;
      resp_data_q      <= 32'h0;
      err_q            <= 1'b0;
      op_q             <= 3'b000;
      off_q            <= 2'b00;
      rt_old_q         <= 32'h0;
      is_write_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      avm_address_q    <= avm_address_d;
      avm_read_q       <= avm_read_d;
      avm_write_q      <= avm_write_d;
      avm_byteenable_q <= avm_byteenable_d;
      avm_writedata_q  <= avm_writedata_d;
      resp_valid_q     <= resp_valid_d;
      resp_data_q      <= resp_data_d;
      err_q            <= err_d;
      op_q             <= op_d;
      off_q            <= off_d;
      rt_old_q         <= rt_old_d;
      is_write_q       <= is_write_d;
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign stall          = (state_q != StIdle);
  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign err            = err_q;
  assign avm_address    = avm_address_q;
  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_byteenable = avm_byteenable_q;
  assign avm_writedata  = avm_writedata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit plus reset and back-to-back sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  loadcontrol = 3'b000;
  logic [1:0]  store_size = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rt_old = 32'h0;
  logic [15:0] imm = 16'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        err;
  logic        stall;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_waitrequest = 1'b0;

  int pass_cnt = 0;
  int total    = 0;

  mem_access_unit dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .loadcontrol     (loadcontrol),
    .store_size      (store_size),
    .addr            (addr),
    .wdata           (wdata),
    .rt_old          (rt_old),
    .imm             (imm),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .err             (err),
    .stall           (stall),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  lc;
    logic [1:0]  ss;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt_old;
    logic [15:0] imm;
    logic [31:0] rdata;
    int          wait_n;
    logic        bus;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_resp;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic wr, input logic [2:0] lc,
                              input logic [1:0] ss, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rt, input logic [15:0] im,
                              input logic [31:0] rd, input int wn, input logic bus,
                              input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = name; v.wr = wr; v.lc = lc; v.ss = ss; v.addr = a; v.wdata = wd;
    v.rt_old = rt; v.imm = im; v.rdata = rd; v.wait_n = wn; v.bus = bus;
    v.exp_addr = ea; v.exp_be = ebe; v.exp_wd = ewd; v.exp_resp = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int rd_cyc;
    @(negedge clk);
    req_valid       = 1'b1;
    req_write       = v.wr;
    loadcontrol     = v.lc;
    store_size      = v.ss;
    addr            = v.addr;
    wdata           = v.wdata;
    rt_old          = v.rt_old;
    imm             = v.imm;
    avm_readdata    = v.rdata;
    avm_waitrequest = (v.wait_n > 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({v.name, ":stall"}, 32'(stall), 32'd1);
    chk({v.name, ":req_ready_busy"}, 32'(req_ready), 32'd0);
    if (v.bus) begin
      chk({v.name, ":address"}, avm_address, v.exp_addr);
      chk({v.name, ":byteenable"}, 32'(avm_byteenable), 32'(v.exp_be));
      chk({v.name, ":rw"}, 32'({avm_read, avm_write}), 32'({!v.wr, v.wr}));
      if (v.wr) chk({v.name, ":writedata"}, avm_writedata, v.exp_wd);
      rd_cyc = 0;
      for (int c = 0; c < v.wait_n; c++) begin
        if (avm_read || avm_write) rd_cyc++;
        @(posedge clk); #1;
        chk({v.name, ":hold_addr"}, avm_address, v.exp_addr);
        chk({v.name, ":hold_be"}, 32'(avm_byteenable), 32'(v.exp_be));
      end
      if (avm_read || avm_write) rd_cyc++;
      avm_waitrequest = 1'b0;
      @(posedge clk); #1;
      chk({v.name, ":bus_cycles"}, 32'(rd_cyc), 32'(v.wait_n + 1));
      chk({v.name, ":bus_released"}, 32'({avm_read, avm_write}), 32'd0);
    end else begin
      chk({v.name, ":no_bus"}, 32'({avm_read, avm_write}), 32'd0);
    end
    chk({v.name, ":resp_valid"}, 32'(resp_valid), 32'd1);
    chk({v.name, ":resp_data"}, resp_data, v.exp_resp);
    chk({v.name, ":err"}, 32'(err), 32'(v.exp_err));
    @(posedge clk); #1;
    chk({v.name, ":resp_one_cycle"}, 32'(resp_valid), 32'd0);
    chk({v.name, ":ready_again"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int seen;
    //                name     wr  lc      ss     addr          wdata         rt_old
    //                imm      rdata         wait bus exp_addr  be  exp_wd  exp_resp  err
    vecs.push_back(mk("lw",    0, 3'b101, 2'b00, 32'h100, 32'h0, 32'h0,
                      16'h0, 32'hDEADBEEF, 2, 1, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk("lb",    0, 3'b000, 2'b00, 32'h103, 32'h0, 32'h0,
                      16'h0, 32'h80112233, 0, 1, 32'h100, 4'hF, 32'h0, 32'hFFFFFF80, 0));
    vecs.push_back(mk("lbu",   0, 3'b001, 2'b00, 32'h103, 32'h0, 32'h0,
                      16'h0, 32'h80112233, 1, 1, 32'h100, 4'hF, 32'h0, 32'h00000080, 0));
    vecs.push_back(mk("lh_hi", 0, 3'b010, 2'b00, 32'h102, 32'h0, 32'h0,
                      16'h0, 32'h80112233, 0, 1, 32'h100, 4'hF, 32'h0, 32'hFFFF8011, 0));
    vecs.push_back(mk("lhu_lo", 0, 3'b011, 2'b00, 32'h200, 32'h0, 32'h0,
                      16'h0, 32'h80118233, 0, 1, 32'h200, 4'hF, 32'h0, 32'h00008233, 0));
    vecs.push_back(mk("lwl1",  0, 3'b110, 2'b00, 32'h101, 32'h0, 32'hAABBCCDD,
                      16'h0, 32'h44332211, 0, 1, 32'h100, 4'hF, 32'h0, 32'h2211CCDD, 0));
    vecs.push_back(mk("lwr1",  0, 3'b111, 2'b00, 32'h101, 32'h0, 32'hAABBCCDD,
                      16'h0, 32'h44332211, 0, 1, 32'h100, 4'hF, 32'h0, 32'hAA443322, 0));
    vecs.push_back(mk("lwl0",  0, 3'b110, 2'b00, 32'h100, 32'h0, 32'hAABBCCDD,
                      16'h0, 32'h44332211, 0, 1, 32'h100, 4'hF, 32'h0, 32'h11BBCCDD, 0));
    vecs.push_back(mk("lwr3",  0, 3'b111, 2'b00, 32'h103, 32'h0, 32'hAABBCCDD,
                      16'h0, 32'h44332211, 0, 1, 32'h100, 4'hF, 32'h0, 32'hAABBCC44, 0));
    vecs.push_back(mk("sb",    1, 3'b000, 2'b00, 32'h102, 32'h000000AB, 32'h0,
                      16'h0, 32'h0, 0, 1, 32'h100, 4'b0100, 32'hABABABAB, 32'h0, 0));
    vecs.push_back(mk("sh",    1, 3'b000, 2'b01, 32'h302, 32'h1234BEEF, 32'h0,
                      16'h0, 32'h0, 1, 1, 32'h300, 4'b1100, 32'hBEEFBEEF, 32'h0, 0));
    vecs.push_back(mk("sw",    1, 3'b000, 2'b10, 32'h104, 32'h12345678, 32'h0,
                      16'h0, 32'h0, 0, 1, 32'h104, 4'b1111, 32'h12345678, 32'h0, 0));
    vecs.push_back(mk("lui",   0, 3'b100, 2'b00, 32'h0, 32'h0, 32'h0,
                      16'h1234, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h12340000, 0));
`ifdef MEM_ALIGN_CHECK_EN
    vecs.push_back(mk("lh_mis", 0, 3'b010, 2'b00, 32'h101, 32'h0, 32'h0,
                      16'h0, 32'h1234F00D, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1));
`else
    vecs.push_back(mk("lh_mis", 0, 3'b010, 2'b00, 32'h101, 32'h0, 32'h0,
                      16'h0, 32'h1234F00D, 0, 1, 32'h100, 4'hF, 32'h0, 32'hFFFFF00D, 0));
`endif

    // Reset values while reset is held.
    #1;
    chk("rst:resp_valid", 32'(resp_valid), 32'd0);
    chk("rst:resp_data", resp_data, 32'd0);
    chk("rst:err", 32'(err), 32'd0);
    chk("rst:stall", 32'(stall), 32'd0);
    chk("rst:rw", 32'({avm_read, avm_write}), 32'd0);
    chk("rst:address", avm_address, 32'd0);
    chk("rst:be", 32'(avm_byteenable), 32'd0);
    chk("rst:wd", avm_writedata, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst:req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Reset in the middle of a stalled read drops it with no response.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; loadcontrol = 3'b101; addr = 32'h200;
    avm_waitrequest = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midrst:read_started", 32'(avm_read), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst:read_dropped", 32'(avm_read), 32'd0);
    chk("midrst:address", avm_address, 32'd0);
    chk("midrst:stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("midrst:no_resp", 32'(seen), 32'd0);
    chk("midrst:ready", 32'(req_ready), 32'd1);

    // req_valid held high: ignored in RESP, accepted again once back in IDLE.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; loadcontrol = 3'b100; imm = 16'h00AB;
    @(posedge clk); #1;
    chk("b2b:first_resp", 32'(resp_valid), 32'd1);
    chk("b2b:first_data", resp_data, 32'h00AB0000);
    @(posedge clk); #1;
    chk("b2b:gap", 32'(resp_valid), 32'd0);
    chk("b2b:idle_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("b2b:second_resp", 32'(resp_valid), 32'd1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b:done", 32'(resp_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have req_valid in 1, req_ready out 1: core request handshake; a request is accepted on a clk edge with both high.
REQ-004 SHALL have req_write in 1 (1 store, 0 load), loadcontrol in 3 (000 LB, 001 LBU, 010 LH, 011 LHU, 100 LUI, 101 LW, 110 LWL, 111 LWR), store_size in 2 (00 byte, 01 half, 10 word).
REQ-005 SHALL have addr in 32 (byte address), wdata in 32 (store data), rt_old in 32 (old rt for LWL/LWR merge), imm in 16 (LUI operand).
REQ-006 SHALL have resp_valid out 1, resp_data out 32, err out 1, stall out 1 (high whenever state is not IDLE).
REQ-007 SHALL have bus master ports avm_address out 32, avm_read out 1, avm_write out 1, avm_byteenable out 4, avm_writedata out 32, avm_readdata in 32, avm_waitrequest in 1.

Function
REQ-008 SHALL implement FSM states IDLE, BUS, RESP; req_ready high only in IDLE.
REQ-009 SHALL, on acceptance of a non-LUI request, go IDLE->BUS and drive registered bus outputs from the next cycle: avm_address = {addr[31:2],2'b00}, exactly one of avm_read/avm_write high.
REQ-010 SHALL hold all avm_* outputs stable in BUS while avm_waitrequest is high.
REQ-011 SHALL complete the transfer on the first BUS cycle with avm_waitrequest low, capture avm_readdata that cycle, deassert avm_read/avm_write, and go to RESP.
REQ-012 SHALL in RESP assert resp_valid for exactly one cycle with resp_data valid, then return to IDLE.
REQ-013 SHALL handle LUI without a bus transaction: IDLE->RESP, resp_data = {imm,16'h0000}, resp_valid one cycle after acceptance.
REQ-014 SHALL use little-endian byte lanes: byte at offset k = bits [8k+7:8k].
REQ-015 SHALL set store byteenable: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; loads 4'b1111; writedata replicates wdata low byte/half across lanes.
REQ-016 SHALL extract loads: LB/LBU selected byte sign/zero-extended; LH/LHU selected half sign/zero-extended; LW whole word.
REQ-017 SHALL merge LWL with k=addr[1:0]: rd = (mem << 8*(3-k)) | (rt_old & ~(32'hFFFFFFFF << 8*(3-k))).
REQ-018 SHALL merge LWR: rd = (mem >> 8k) | (rt_old & ~(32'hFFFFFFFF >> 8k)).
REQ-019 SHALL drive resp_data = 0 for stores; resp_valid still pulses.
REQ-020 SHALL ignore req_valid outside IDLE; a new request may be accepted in the cycle after RESP.

Reset
REQ-021 SHALL on reset assertion immediately enter IDLE and drive resp_valid, resp_data, err, avm_read, avm_write, avm_address, avm_byteenable, avm_writedata, stall all to 0; req_ready 1 after reset release.
REQ-022 SHALL abandon any in-flight transfer on reset mid-BUS without a response.

Configuration
REQ-023 SHALL, with MEM_ALIGN_CHECK_EN defined, flag halfword at addr[0]=1 or LW/SW at addr[1:0]!=0: no bus transaction, IDLE->RESP, resp_valid one cycle after acceptance with err=1, resp_data=0; LWL/LWR/byte exempt.
REQ-024 SHALL, without MEM_ALIGN_CHECK_EN, tie err to 0 and force alignment (addr[0] ignored for halfword, addr[1:0] ignored for LW/SW).

Verification
REQ-025 LW addr 0x100, readdata 0xDEADBEEF, waitrequest high 2 cycles -> avm_read held 3 cycles, resp_data 0xDEADBEEF one cycle later.
REQ-026 LB addr 0x103, readdata 0x80112233 -> resp_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-027 SB addr 0x102, wdata 0x000000AB -> avm_byteenable 4'b0100, writedata 0xABABABAB, resp_data 0.
REQ-028 LWL addr 0x101, mem 0x44332211, rt_old 0xAABBCCDD -> 0x2211CCDD; LWR same addr -> 0xAA443322.
REQ-029 LUI imm 0x1234 -> no avm_read, resp_data 0x12340000 one cycle after acceptance.
REQ-030 LH addr 0x101 -> with MEM_ALIGN_CHECK_EN err=1 no bus access; without, byteenable 4'b1111 and lanes [15:0] used; reset mid-BUS -> avm_read 0 immediately, no resp_valid.
